uart_rx: RTL and testbench

UART receive path. It is the counterpart of the UART_TX frame serialiser.
- Oversamples the serial line RX_IN by a runtime prescale.
- Detects the start bit and majority-votes each bit at mid-period.
- Deserialises LSB-first data, then checks optional parity and the stop bit.
- Presents the byte on P_DATA with a one-cycle DATA_VALID pulse.
- Sits between the pad/synchroniser and the system-side register/FIFO logic.

---
 rtl/uart_rx_if.sv | 39 +++
 rtl/uart_rx.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Bundles the uart_rx serial input, frame configuration and received-byte outputs.
// The slave modport is the receiver's view; master is the system/driver side.
interface uart_rx_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
);

  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport master (
    output RX_IN,
    output PAR_EN,
    output PAR_TYP,
    output PRESCALE,
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_ERR,
    input  STP_ERR
  );

  modport slave (
    input  RX_IN,
    input  PAR_EN,
    input  PAR_TYP,
    input  PRESCALE,
    output P_DATA,
    output DATA_VALID,
    output PAR_ERR,
    output STP_ERR
  );

endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, 3-sample majority vote, LSB-first data,
// optional parity and stop check. Define UART_RX_SYNC_EN to add a 2-flop RX_IN synchroniser.
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input logic      CLK,
  input logic      RST,
  uart_rx_if.slave bus
);

  localparam int unsigned CntW    = 6;
  localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       edge_cnt_q, edge_cnt_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0]       p_q, p_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [2:0]            samples_q, samples_d;
  logic                  vote_q, vote_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bad_q, par_bad_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic                  rx;
  logic [CntW-1:0]       p_sel;
  logic [CntW-1:0]       half;
  logic                  last_edge;
  logic                  sample_en;
  logic                  vote_en;
  logic                  start_det;
  logic                  par_exp;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Reset to 1 so the idle line is not mistaken for a start bit after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.RX_IN};
    end
  end

  assign rx = sync_q[1];
`else
  assign rx = bus.RX_IN;
`endif

  always_comb begin
    p_sel = CntW'(8);
    if (bus.PRESCALE == PRESCALE_W'(16)) begin
      p_sel = CntW'(16);
    end else if (bus.PRESCALE == PRESCALE_W'(32)) begin
      p_sel = CntW'(32);
    end
  end

  assign half      = p_q >> 1;
  assign last_edge = (edge_cnt_q == p_q - CntW'(1));
  assign sample_en = (edge_cnt_q == half - CntW'(1)) || (edge_cnt_q == half) ||
                     (edge_cnt_q == half + CntW'(1));
  assign vote_en   = (edge_cnt_q == half + CntW'(2));
  assign start_det = (state_q == StIdle) && !rx;
  assign par_exp   = (^shift_q) ^ par_typ_q;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!rx) state_d = StStart;
      end
      StStart: begin
        // A start bit that votes 1 was a glitch; drop it silently.
        if (last_edge) state_d = vote_q ? StIdle : StData;
      end
      StData: begin
        if (last_edge && (bit_cnt_q == LastBit)) state_d = par_en_q ? StParity : StStop;
      end
      StParity: begin
        if (last_edge) state_d = StStop;
      end
      StStop: begin
        if (last_edge) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counters, sampling, datapath and registered-output next values.
  always_comb begin
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    p_d          = p_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    samples_d    = samples_q;
    vote_d       = vote_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    if (state_q == StIdle) begin
      // The cycle the line is first seen low is edge 0 of the start bit.
      edge_cnt_d = start_det ? CntW'(1) : '0;
    end else begin
      edge_cnt_d = last_edge ? '0 : edge_cnt_q + CntW'(1);
    end

    if (start_det) begin
      p_d       = p_sel;
      par_en_d  = bus.PAR_EN;
      par_typ_d = bus.PAR_TYP;
      par_bad_d = 1'b0;
      bit_cnt_d = '0;
    end

    if ((state_q != StIdle) && sample_en) begin
      samples_d = {samples_q[1:0], rx};
    end

    if ((state_q != StIdle) && vote_en) begin
      vote_d = (samples_q[0] & samples_q[1]) | (samples_q[0] & samples_q[2]) |
               (samples_q[1] & samples_q[2]);
    end

    if (last_edge) begin
      unique case (state_q)
        StData: begin
          shift_d   = {vote_q, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + BitCntW'(1);
        end
        StParity: begin
          if (vote_q != par_exp) begin
            par_err_d = 1'b1;
            par_bad_d = 1'b1;
          end
        end
        StStop: begin
          if (!vote_q) begin
            stp_err_d = 1'b1;
          end else if (!par_bad_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      p_q          <= CntW'(8);
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      samples_q    <= '0;
      vote_q       <= 1'b0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      p_q          <= p_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      samples_q    <= samples_d;
      vote_q       <= vote_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  // Output logic.
  always_comb begin
    bus.P_DATA     = p_data_q;
    bus.DATA_VALID = data_valid_q;
    bus.PAR_ERR    = par_err_q;
    bus.STP_ERR    = stp_err_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames with hand-computed bytes, latencies and error pulses.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int Extra = 2;
`else
  localparam int Extra = 0;
`endif

  logic CLK;
  logic RST;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // Event log written only by the monitor.
  int   dv_cnt = 0;
  int   pe_cnt = 0;
  int   se_cnt = 0;
  int   long_cnt = 0;
  int   pe_last = -1;
  int   se_last = -1;
  int   dv_cyc[$];
  logic [7:0] dv_dat[$];
  logic prev_hi = 1'b0;

  uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.DATA_VALID === 1'b1) begin
      dv_cnt <= dv_cnt + 1;
      dv_cyc.push_back(cyc);
      dv_dat.push_back(bus.P_DATA);
    end
    if (bus.PAR_ERR === 1'b1) begin
      pe_cnt  <= pe_cnt + 1;
      pe_last <= cyc;
    end
    if (bus.STP_ERR === 1'b1) begin
      se_cnt  <= se_cnt + 1;
      se_last <= cyc;
    end
    if (prev_hi && ((bus.DATA_VALID | bus.PAR_ERR | bus.STP_ERR) === 1'b1)) begin
      long_cnt <= long_cnt + 1;
    end
    prev_hi <= ((bus.DATA_VALID | bus.PAR_ERR | bus.STP_ERR) === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int p);
    bus.RX_IN = b;
    tick(p);
  endtask

  task automatic send_frame(input int p, input logic [7:0] d, input logic par_en,
                            input logic par_bit, input logic stop_bit, output int start_c);
    start_c = cyc;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (par_en) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
    bus.RX_IN = 1'b1;
  endtask

  function automatic int dv_lat(input int idx, input int st);
    return (dv_cyc.size() > idx) ? dv_cyc[idx] - st : -1;
  endfunction

  function automatic logic [7:0] dv_byte(input int idx);
    return (dv_dat.size() > idx) ? dv_dat[idx] : 8'hxx;
  endfunction

  task automatic test_reset();
    RST          = 1'b0;
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.PRESCALE = 6'd8;
    tick(3);
    total++; if (bus.P_DATA !== 8'h00) begin bad++;
      $display("FAIL reset_pdata: got %h want 00", bus.P_DATA); end
    total++; if (bus.DATA_VALID !== 1'b0) begin bad++;
      $display("FAIL reset_dv: got %b want 0", bus.DATA_VALID); end
    total++; if (bus.PAR_ERR !== 1'b0) begin bad++;
      $display("FAIL reset_parerr: got %b want 0", bus.PAR_ERR); end
    total++; if (bus.STP_ERR !== 1'b0) begin bad++;
      $display("FAIL reset_stperr: got %b want 0", bus.STP_ERR); end
    RST = 1'b1;
    tick(4);
  endtask

  task automatic test_basic();
    int st, b_dv, b_pe, b_se, b_lg;
    bus.PRESCALE = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt; b_lg = long_cnt;
    send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1, st);
    tick(4);
    total++; if (dv_cnt - b_dv !== 1) begin bad++;
      $display("FAIL basic_dv_count: got %0d want 1", dv_cnt - b_dv); end
    total++; if (dv_lat(b_dv, st) !== 80 + Extra) begin bad++;
      $display("FAIL basic_latency: got %0d want %0d", dv_lat(b_dv, st), 80 + Extra); end
    total++; if (dv_byte(b_dv) !== 8'hA5) begin bad++;
      $display("FAIL basic_data: got %h want a5", dv_byte(b_dv)); end
    total++; if ((pe_cnt - b_pe) + (se_cnt - b_se) !== 0) begin bad++;
      $display("FAIL basic_errors: got %0d want 0", (pe_cnt - b_pe) + (se_cnt - b_se)); end
    total++; if (long_cnt - b_lg !== 0) begin bad++;
      $display("FAIL basic_pulse_width: got %0d long pulses want 0", long_cnt - b_lg); end
    total++; if (bus.P_DATA !== 8'hA5) begin bad++;
      $display("FAIL basic_hold: got %h want a5", bus.P_DATA); end
  endtask

  task automatic test_parity_even();
    int st, b_dv, b_pe;
    bus.PRESCALE = 6'd16; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
    b_dv = dv_cnt; b_pe = pe_cnt;
    send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b1, st);
    tick(4);
    total++; if (dv_lat(b_dv, st) !== 176 + Extra) begin bad++;
      $display("FAIL par_good_latency: got %0d want %0d", dv_lat(b_dv, st), 176 + Extra); end
    total++; if (dv_byte(b_dv) !== 8'h3C) begin bad++;
      $display("FAIL par_good_data: got %h want 3c", dv_byte(b_dv)); end
    total++; if (pe_cnt - b_pe !== 0) begin bad++;
      $display("FAIL par_good_parerr: got %0d want 0", pe_cnt - b_pe); end
    // Same byte with the wrong parity bit.
    b_dv = dv_cnt; b_pe = pe_cnt;
    send_frame(16, 8'h3C, 1'b1, 1'b1, 1'b1, st);
    tick(4);
    total++; if (pe_cnt - b_pe !== 1) begin bad++;
      $display("FAIL par_bad_parerr: got %0d want 1", pe_cnt - b_pe); end
    total++; if (pe_last - st !== 160 + Extra) begin bad++;
      $display("FAIL par_bad_time: got %0d want %0d", pe_last - st, 160 + Extra); end
    total++; if (dv_cnt - b_dv !== 0) begin bad++;
      $display("FAIL par_bad_dv: got %0d want 0", dv_cnt - b_dv); end
    total++; if (bus.P_DATA !== 8'h3C) begin bad++;
      $display("FAIL par_bad_hold: got %h want 3c", bus.P_DATA); end
  endtask

  task automatic test_odd_stop();
    int st, b_dv, b_pe, b_se;
    bus.PRESCALE = 6'd8; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1;
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    send_frame(8, 8'h00, 1'b1, 1'b0, 1'b0, st);
    tick(4);
    total++; if (pe_cnt - b_pe !== 1) begin bad++;
      $display("FAIL odd_parerr: got %0d want 1", pe_cnt - b_pe); end
    total++; if (pe_last - st !== 80 + Extra) begin bad++;
      $display("FAIL odd_parerr_time: got %0d want %0d", pe_last - st, 80 + Extra); end
    total++; if (se_cnt - b_se !== 1) begin bad++;
      $display("FAIL odd_stperr: got %0d want 1", se_cnt - b_se); end
    total++; if (se_last - st !== 88 + Extra) begin bad++;
      $display("FAIL odd_stperr_time: got %0d want %0d", se_last - st, 88 + Extra); end
    total++; if (dv_cnt - b_dv !== 0) begin bad++;
      $display("FAIL odd_dv: got %0d want 0", dv_cnt - b_dv); end
    total++; if (bus.P_DATA !== 8'h3C) begin bad++;
      $display("FAIL odd_hold: got %h want 3c", bus.P_DATA); end
  endtask

  task automatic test_glitch();
    int b_dv, b_pe, b_se;
    bus.PRESCALE = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    bus.RX_IN = 1'b0;
    tick(2);
    bus.RX_IN = 1'b1;
    tick(100);
    total++; if (dv_cnt - b_dv !== 0) begin bad++;
      $display("FAIL glitch_dv: got %0d want 0", dv_cnt - b_dv); end
    total++; if (pe_cnt - b_pe !== 0) begin bad++;
      $display("FAIL glitch_parerr: got %0d want 0", pe_cnt - b_pe); end
    total++; if (se_cnt - b_se !== 0) begin bad++;
      $display("FAIL glitch_stperr: got %0d want 0", se_cnt - b_se); end
  endtask

  task automatic test_back_to_back();
    int st1, st2, b_dv, b_se;
    bus.PRESCALE = 6'd32; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    b_dv = dv_cnt; b_se = se_cnt;
    send_frame(32, 8'h55, 1'b0, 1'b0, 1'b1, st1);
    send_frame(32, 8'hAA, 1'b0, 1'b0, 1'b1, st2);
    tick(4);
    total++; if (dv_cnt - b_dv !== 2) begin bad++;
      $display("FAIL b2b_dv_count: got %0d want 2", dv_cnt - b_dv); end
    total++; if (dv_lat(b_dv, st1) !== 320 + Extra) begin bad++;
      $display("FAIL b2b_latency: got %0d want %0d", dv_lat(b_dv, st1), 320 + Extra); end
    total++; if (dv_lat(b_dv + 1, st1) - dv_lat(b_dv, st1) !== 320) begin bad++;
      $display("FAIL b2b_spacing: got %0d want 320",
               dv_lat(b_dv + 1, st1) - dv_lat(b_dv, st1)); end
    total++; if (dv_byte(b_dv) !== 8'h55) begin bad++;
      $display("FAIL b2b_data0: got %h want 55", dv_byte(b_dv)); end
    total++; if (dv_byte(b_dv + 1) !== 8'hAA) begin bad++;
      $display("FAIL b2b_data1: got %h want aa", dv_byte(b_dv + 1)); end
    total++; if (se_cnt - b_se !== 0) begin bad++;
      $display("FAIL b2b_stperr: got %0d want 0", se_cnt - b_se); end
  endtask

  task automatic test_reset_mid();
    int st, b_dv, b_pe, b_se;
    logic [7:0] part;
    part = 8'h5A;
    bus.PRESCALE = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(part[i], 8);
    RST = 1'b0;
    bus.RX_IN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR} !== 11'd0) begin
        bad++;
        $display("FAIL midreset_outputs: got %h/%b%b%b want 00/000", bus.P_DATA,
                 bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR);
      end
      tick(1);
    end
    RST = 1'b1;
    tick(20);
    total++; if ((dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se) !== 0) begin bad++;
      $display("FAIL midreset_discard: got %0d events want 0",
               (dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se)); end
    send_frame(8, 8'h81, 1'b0, 1'b0, 1'b1, st);
    tick(4);
    total++; if (dv_cnt - b_dv !== 1) begin bad++;
      $display("FAIL midreset_dv_count: got %0d want 1", dv_cnt - b_dv); end
    total++; if (dv_byte(b_dv) !== 8'h81) begin bad++;
      $display("FAIL midreset_data: got %h want 81", dv_byte(b_dv)); end
    total++; if (dv_lat(b_dv, st) !== 80 + Extra) begin bad++;
      $display("FAIL midreset_latency: got %0d want %0d", dv_lat(b_dv, st), 80 + Extra); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_even();
    test_odd_stop();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
